mem_access: RTL and testbench
=============================

# mem_access

Memory-access stage of the five-stage RV32I pipeline. Sits between `exe_mem` and `mem_wb`: it passes ALU results through, and for loads and stores it runs a request/grant/response handshake on the data bus. It stalls the pipeline while an access is outstanding, then hands the aligned, sign- or zero-extended load data to `mem_wb`.

## Interface
Parameters:
- `ADDR_W`, 32, data-bus address width.
- `DATA_W`, 32, data-bus and register width; only 32 is supported.

Ports:
- `clk_i`  in  1  pipeline clock.
- `rst_i`  in  1  reset; synchronous, active-low.
- `valid_i`  in  1  `exe_mem` slot holds a new instruction this cycle.
- `reg_waddr_i`  in  5  destination register.
- `reg_we_i`  in  1  register write enable.
- `reg_wdata_i`  in  32  ALU result; passed through for non-loads.
- `mem_re_i`  in  1  instruction is a load.
- `mem_we_i`  in  1  instruction is a store.
- `mem_op_i`  in  3  funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- `mem_addr_i`  in  32  effective byte address.
- `mem_wdata_i`  in  32  store data (rs2).
- `reg_waddr_o`  out  5  to `mem_wb`.
- `reg_we_o`  out  1  to `mem_wb`.
- `reg_wdata_o`  out  32  to `mem_wb`.
- `dbus_req_o`  out  1  bus request.
- `dbus_we_o`  out  1  1 = write.
- `dbus_addr_o`  out  32  word-aligned address: `{mem_addr_i[31:2],2'b00}`.
- `dbus_be_o`  out  4  byte enables.
- `dbus_wdata_o`  out  32  lane-replicated store data.
- `dbus_gnt_i`  in  1  request accepted.
- `dbus_rvalid_i`  in  1  read data valid.
- `dbus_rdata_i`  in  32  read data.
- `stall_o`  out  1  to pipeline control; freezes PC through `exe_mem`.
- `misalign_o`  out  1  one-cycle misaligned-access flag.

## Operation
FSM states and transitions:
- `IDLE`: goes to `REQ` when `valid_i & (mem_re_i|mem_we_i)` and the access is aligned.
- `REQ`: waits for `dbus_gnt_i`. A granted store goes to `IDLE`; a granted load goes to `RESP`.
- `RESP`: waits for `dbus_rvalid_i`, then goes to `IDLE`.

Bus and stall behaviour:
- `dbus_req_o` is asserted combinationally in the first cycle of the access (IDLE with a qualifying access) and stays high through `REQ` until granted.
- Address, `we`, `be` and `wdata` are held stable while `dbus_req_o` is high.
- `stall_o` = access in flight and not completing this cycle.
- A store completes in its `gnt` cycle. A load completes in its `rvalid` cycle.

Byte enables and store data:
- SB: `be = 4'b0001 << addr[1:0]`; the byte is replicated across all four lanes.
- SH: `be = 4'b0011 << addr[1:0]`; the half is replicated across both halves.
- SW: `be = 4'b1111`.
- Loads drive `be = 4'b1111`.

Load extraction:
- Select the lane with `addr[1:0]`.
- LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- The result drives `reg_wdata_o` combinationally in the `rvalid` cycle.

Outputs by case:
- Non-memory ops: all `reg_*_o` follow the inputs; `stall_o = 0`.
- Stores: `reg_we_o = 0`.
- Loads in the completion cycle: `reg_we_o = reg_we_i`.
- In all non-completing stall cycles: `reg_we_o = 0` (a bubble into `mem_wb`).

Misalignment:
- A halfword at an odd address, or a word with `addr[1:0] != 0`, issues no request.
- `misalign_o = 1` for that cycle, `reg_we_o = 0`, no stall; the FSM stays in `IDLE`.

Other rules:
- Reset, `rst_i = 0`: FSM goes to `IDLE`. `dbus_req_o`, `stall_o`, `misalign_o` and `reg_we_o` are 0; `reg_waddr_o` and `reg_wdata_o` are 0.
- Reset mid-access abandons the access. A late `dbus_rvalid_i` arriving in `IDLE` is ignored.
- `dbus_rvalid_i` in the same cycle as `gnt` is illegal; the bus guarantees `rvalid` comes at least one cycle after `gnt`.
- `valid_i = 0` means no access and forces `reg_we_o = 0`.

## Timing
- Non-memory op: 0 extra cycles; outputs are combinational from the inputs.
- Store with `gnt` in the first cycle: 0 stall cycles.
- Store, general case: stall = number of cycles before `gnt`.
- Load, best case (`gnt` in cycle 0, `rvalid` in cycle 1): 1 stall cycle.
- Load, general case: stall = cycles to `gnt` + cycles from `gnt` to `rvalid`, with `rvalid` at least one cycle after `gnt`.
- The inputs are held by the upstream stall, so they stay constant for the whole access.

## Structure
- `defines.v` holds:
  - funct3 load/store encodings (`LB`…`SW`);
  - the `RstEnable` value of 1'b0;
  - `ZeroWord`, `ZeroReg`, `RegBus`, `RegAddrBus`;
  - the FSM state encoding `MemIdle`/`MemReq`/`MemResp`.
- One sub-module, `lsu_align`: combinational byte-enable, store replication and load extraction/extension. The FSM and muxing stay in `mem_access`.

## Test plan
- ADD result `0x1234` to x5, no mem op -> same-cycle `reg_wdata_o = 0x1234`, `reg_we_o = 1`, `stall_o = 0`.
- SB `0xAB` at `0x1003`, `gnt` in cycle 0 -> `be = 4'b1000`, `wdata = 0xABABABAB`, addr `0x1000`, no stall, `reg_we_o = 0`.
- LH at `0x2002`, `gnt` after 2 cycles, `rvalid` 3 cycles later with `rdata = 0x8001_0000` -> `stall_o` high 5 cycles, then `reg_wdata_o = 0xFFFF8001`. LHU of the same access gives `0x00008001`.
- LW at `0x3001` -> `misalign_o = 1` for one cycle, `dbus_req_o = 0`, `reg_we_o = 0`, no stall.
- LW at `0x4000`, `rst_i` low in the `RESP` state, late `rvalid` arrives after reset -> FSM in `IDLE`, `stall_o = 0`, all outputs zero, and the late `rvalid` produces no write.
- Back-to-back SW then LBU (`rdata = 0x0000_00F0` at `0x5000`) -> two separate requests, stall-free store, LBU result `0x000000F0`.

Source files
------------

// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared encodings and types for the memory-access stage
package mem_access_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam logic       RST_ENABLE = 1'b0;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [4:0]  ZERO_REG  = 5'd0;

  typedef logic [31:0] reg_bus_t;
  typedef logic [4:0]  reg_addr_bus_t;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_RESP = 2'd2
  } mem_state_e;

  // funct3[1:0] encodes the access size for both loads and stores
  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] offset);
    case (op[1:0])
      2'b01:   return offset[0];
      2'b10:   return |offset;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_lsu_align.sv
// rtl/mem_access_lsu_align.sv - byte enables, store lane replication, load extraction
module lsu_align
  import mem_access_pkg::*;
(
  input  logic [2:0] op_i,
  input  logic [1:0] offset_i,
  input  logic       is_store_i,
  input  reg_bus_t   wdata_i,
  input  reg_bus_t   rdata_i,
  output logic [3:0] be_o,
  output reg_bus_t   wdata_o,
  output reg_bus_t   rdata_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    if (is_store_i) begin
      case (op_i)
        SB: begin
          be_o    = 4'b0001 << offset_i;
          wdata_o = {4{wdata_i[7:0]}};
        end
        SH: begin
          be_o    = 4'b0011 << offset_i;
          wdata_o = {2{wdata_i[15:0]}};
        end
        default: begin
          be_o    = 4'b1111;
          wdata_o = wdata_i;
        end
      endcase
    end
  end

  always_comb begin
    lane_b = rdata_i[{offset_i, 3'b000} +: 8];
    lane_h = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (op_i)
      LB:      rdata_o = {{24{lane_b[7]}}, lane_b};
      LH:      rdata_o = {{16{lane_h[15]}}, lane_h};
      LBU:     rdata_o = {24'd0, lane_b};
      LHU:     rdata_o = {16'd0, lane_h};
      default: rdata_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - pipeline memory stage: data-bus handshake, stall and writeback muxing
module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [4:0]        reg_waddr_i,
  input  logic              reg_we_i,
  input  logic [DATA_W-1:0] reg_wdata_i,
  input  logic              mem_re_i,
  input  logic              mem_we_i,
  input  logic [2:0]        mem_op_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [4:0]        reg_waddr_o,
  output logic              reg_we_o,
  output logic [DATA_W-1:0] reg_wdata_o,
  output logic              dbus_req_o,
  output logic              dbus_we_o,
  output logic [ADDR_W-1:0] dbus_addr_o,
  output logic [3:0]        dbus_be_o,
  output logic [DATA_W-1:0] dbus_wdata_o,
  input  logic              dbus_gnt_i,
  input  logic              dbus_rvalid_i,
  input  logic [DATA_W-1:0] dbus_rdata_i,
  output logic              stall_o,
  output logic              misalign_o
);

  mem_state_e state, state_next;

  logic        access;
  logic        misaligned;
  logic [3:0]  be;
  reg_bus_t    wdata_rep;
  reg_bus_t    load_data;

  assign access     = valid_i & (mem_re_i | mem_we_i);
  assign misaligned = is_misaligned(mem_op_i, mem_addr_i[1:0]);

  lsu_align u_align (
    .op_i       (mem_op_i),
    .offset_i   (mem_addr_i[1:0]),
    .is_store_i (mem_we_i),
    .wdata_i    (mem_wdata_i),
    .rdata_i    (dbus_rdata_i),
    .be_o       (be),
    .wdata_o    (wdata_rep),
    .rdata_o    (load_data)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i == RST_ENABLE) begin
      state <= MEM_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    dbus_req_o  = 1'b0;
    stall_o     = 1'b0;
    misalign_o  = 1'b0;
    reg_waddr_o = reg_waddr_i;
    reg_wdata_o = reg_wdata_i;
    reg_we_o    = valid_i & reg_we_i;

    case (state)
      MEM_IDLE: begin
        if (access) begin
          reg_we_o = 1'b0;
          if (misaligned) begin
            misalign_o = 1'b1;
          end else begin
            dbus_req_o = 1'b1;
            if (dbus_gnt_i && mem_we_i) begin
              state_next = MEM_IDLE;
            end else begin
              stall_o    = 1'b1;
              state_next = dbus_gnt_i ? MEM_RESP : MEM_REQ;
            end
          end
        end
      end
      MEM_REQ: begin
        dbus_req_o = 1'b1;
        reg_we_o   = 1'b0;
        stall_o    = 1'b1;
        if (dbus_gnt_i) begin
          if (mem_we_i) begin
            stall_o    = 1'b0;
            state_next = MEM_IDLE;
          end else begin
            state_next = MEM_RESP;
          end
        end
      end
      MEM_RESP: begin
        reg_we_o = 1'b0;
        stall_o  = 1'b1;
        if (dbus_rvalid_i) begin
          stall_o     = 1'b0;
          reg_we_o    = reg_we_i;
          reg_wdata_o = load_data;
          state_next  = MEM_IDLE;
        end
      end
      default: state_next = MEM_IDLE;
    endcase

    // reset wins over everything so mem_wb sees a clean bubble
    if (rst_i == RST_ENABLE) begin
      state_next  = MEM_IDLE;
      dbus_req_o  = 1'b0;
      stall_o     = 1'b0;
      misalign_o  = 1'b0;
      reg_we_o    = 1'b0;
      reg_waddr_o = ZERO_REG;
      reg_wdata_o = ZERO_WORD;
    end

    dbus_we_o    = dbus_req_o & mem_we_i;
    dbus_addr_o  = dbus_req_o ? {mem_addr_i[ADDR_W-1:2], 2'b00} : '0;
    dbus_be_o    = dbus_req_o ? be : 4'b0000;
    dbus_wdata_o = (dbus_req_o && mem_we_i) ? wdata_rep : '0;
  end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - self-checking bench for the memory-access stage
module tb_mem_access;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [4:0]  reg_waddr_i;
  logic        reg_we_i;
  logic [31:0] reg_wdata_i;
  logic        mem_re_i;
  logic        mem_we_i;
  logic [2:0]  mem_op_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [4:0]  reg_waddr_o;
  logic        reg_we_o;
  logic [31:0] reg_wdata_o;
  logic        dbus_req_o;
  logic        dbus_we_o;
  logic [31:0] dbus_addr_o;
  logic [3:0]  dbus_be_o;
  logic [31:0] dbus_wdata_o;
  logic        dbus_gnt_i;
  logic        dbus_rvalid_i;
  logic [31:0] dbus_rdata_i;
  logic        stall_o;
  logic        misalign_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  mem_access #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i),
    .reg_waddr_i(reg_waddr_i), .reg_we_i(reg_we_i), .reg_wdata_i(reg_wdata_i),
    .mem_re_i(mem_re_i), .mem_we_i(mem_we_i), .mem_op_i(mem_op_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .reg_waddr_o(reg_waddr_o), .reg_we_o(reg_we_o), .reg_wdata_o(reg_wdata_o),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
    .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o),
    .dbus_gnt_i(dbus_gnt_i), .dbus_rvalid_i(dbus_rvalid_i), .dbus_rdata_i(dbus_rdata_i),
    .stall_o(stall_o), .misalign_o(misalign_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: access size in bytes from funct3, then plain arithmetic.
  function automatic int m_size(input logic [2:0] op);
    return 1 << op[1:0];
  endfunction

  function automatic logic m_mis(input logic [2:0] op, input logic [31:0] addr);
    return (addr % m_size(op)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic ld, input logic [2:0] op, input logic [31:0] addr);
    logic [7:0] mask;
    if (ld) return 4'hF;
    mask = ((8'd1 << m_size(op)) - 8'd1) << addr[1:0];
    return mask[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] op, input logic [31:0] wd);
    case (m_size(op))
      1:       return wd[7:0] * 32'h0101_0101;
      2:       return wd[15:0] * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] rd);
    int nb = m_size(op);
    logic [31:0] v, mask;
    v = rd >> (8 * addr[1:0]);
    if (nb == 4) return v;
    mask = (32'd1 << (8 * nb)) - 32'd1;
    v = v & mask;
    if (!op[2] && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  // One access from the first cycle to completion; bus grants after g cycles,
  // read data r cycles after the grant. Leaves the bench just after a rising edge.
  task automatic do_access(input string nm, input logic ld, input logic [2:0] op,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                           input int g, input int r, input logic we, input logic [4:0] wa,
                           input logic mis, input logic [3:0] be, input logic [31:0] wdata,
                           input logic [31:0] result, input int stall_exp);
    int total = mis ? 0 : (ld ? g + r : g);
    int stalls = 0;
    valid_i = 1'b1; mem_re_i = ld; mem_we_i = !ld; mem_op_i = op;
    mem_addr_i = addr; mem_wdata_i = wd; reg_we_i = we; reg_waddr_i = wa;
    reg_wdata_i = $urandom;
    for (int c = 0; c <= total; c++) begin
      dbus_gnt_i    = !mis && (c == g);
      dbus_rvalid_i = !mis && ld && (c == g + r);
      dbus_rdata_i  = dbus_rvalid_i ? rd : $urandom;
      #4;
      if (stall_o) stalls++;
      chk({nm, " stall"}, {31'd0, stall_o}, {31'd0, c < total});
      chk({nm, " misalign"}, {31'd0, misalign_o}, {31'd0, mis && c == 0});
      chk({nm, " req"}, {31'd0, dbus_req_o}, {31'd0, !mis && c <= g});
      if (!mis && c <= g) begin
        chk({nm, " addr"}, dbus_addr_o, {addr[31:2], 2'b00});
        chk({nm, " we"}, {31'd0, dbus_we_o}, {31'd0, !ld});
        chk({nm, " be"}, {28'd0, dbus_be_o}, {28'd0, be});
        if (!ld) chk({nm, " wdata"}, dbus_wdata_o, wdata);
      end
      chk({nm, " reg_we"}, {31'd0, reg_we_o}, {31'd0, ld && !mis && c == total && we});
      if (ld && !mis && c == total) begin
        chk({nm, " result"}, reg_wdata_o, result);
        chk({nm, " waddr"}, {27'd0, reg_waddr_o}, {27'd0, wa});
      end
      @(posedge clk_i); #1;
    end
    dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0;
    chk({nm, " stall cycles"}, stalls, stall_exp);
  endtask

  typedef struct {
    string       nm;
    logic        ld;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    int          g;
    int          r;
    logic        mis;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] result;
    int          stall;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{"sb_1003",  1'b0, 3'b000, 32'h1003, 32'h0000_00AB, 32'h0, 0, 1, 1'b0, 4'b1000, 32'hABAB_ABAB, 32'h0, 0};
    tbl[1] = '{"lh_2002",  1'b1, 3'b001, 32'h2002, 32'h0, 32'h8001_0000, 2, 3, 1'b0, 4'b1111, 32'h0, 32'hFFFF_8001, 5};
    tbl[2] = '{"lhu_2002", 1'b1, 3'b101, 32'h2002, 32'h0, 32'h8001_0000, 2, 3, 1'b0, 4'b1111, 32'h0, 32'h0000_8001, 5};
    tbl[3] = '{"lw_3001",  1'b1, 3'b010, 32'h3001, 32'h0, 32'h0, 0, 1, 1'b1, 4'b1111, 32'h0, 32'h0, 0};
    tbl[4] = '{"sw_5000",  1'b0, 3'b010, 32'h5000, 32'h1234_5678, 32'h0, 0, 1, 1'b0, 4'b1111, 32'h1234_5678, 32'h0, 0};
    tbl[5] = '{"lbu_5000", 1'b1, 3'b100, 32'h5000, 32'h0, 32'h0000_00F0, 0, 1, 1'b0, 4'b1111, 32'h0, 32'h0000_00F0, 1};
    tbl[6] = '{"sh_6002",  1'b0, 3'b001, 32'h6002, 32'h5555_BEEF, 32'h0, 1, 1, 1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0, 1};
    tbl[7] = '{"lb_7001",  1'b1, 3'b000, 32'h7001, 32'h0, 32'h0000_8000, 0, 2, 1'b0, 4'b1111, 32'h0, 32'hFFFF_FF80, 2};
    tbl[8] = '{"sh_6001",  1'b0, 3'b001, 32'h6001, 32'h0, 32'h0, 0, 1, 1'b1, 4'b0011, 32'h0, 32'h0, 0};
    tbl[9] = '{"lw_8000",  1'b1, 3'b010, 32'h8000, 32'h0, 32'hDEAD_BEEF, 1, 1, 1'b0, 4'b1111, 32'h0, 32'hDEAD_BEEF, 2};

    // Reset with a live ALU op on the inputs: everything must read zero.
    rst_i = 1'b0; valid_i = 1'b1; reg_waddr_i = 5'd5; reg_we_i = 1'b1; reg_wdata_i = 32'h1234;
    mem_re_i = 1'b0; mem_we_i = 1'b0; mem_op_i = 3'b010; mem_addr_i = 32'h0; mem_wdata_i = 32'h0;
    dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0; dbus_rdata_i = 32'h0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst reg_we", {31'd0, reg_we_o}, 32'd0);
    chk("rst wdata", reg_wdata_o, 32'd0);
    chk("rst waddr", {27'd0, reg_waddr_o}, 32'd0);
    chk("rst stall", {31'd0, stall_o}, 32'd0);
    chk("rst req", {31'd0, dbus_req_o}, 32'd0);
    chk("rst misalign", {31'd0, misalign_o}, 32'd0);
    rst_i = 1'b1;
    #4;
    chk("add wdata", reg_wdata_o, 32'h1234);
    chk("add we", {31'd0, reg_we_o}, 32'd1);
    chk("add waddr", {27'd0, reg_waddr_o}, 32'd5);
    chk("add stall", {31'd0, stall_o}, 32'd0);
    valid_i = 1'b0;
    #1;
    chk("invalid we", {31'd0, reg_we_o}, 32'd0);
    @(posedge clk_i); #1;

    // Directed vectors, applied back to back.
    for (int i = 0; i < 10; i++)
      do_access(tbl[i].nm, tbl[i].ld, tbl[i].op, tbl[i].addr, tbl[i].wd, tbl[i].rd,
                tbl[i].g, tbl[i].r, 1'b1, 5'(i + 1), tbl[i].mis, tbl[i].be,
                tbl[i].wdata, tbl[i].result, tbl[i].stall);

    // Reset during RESP, then a stray rvalid after reset.
    valid_i = 1'b1; mem_re_i = 1'b1; mem_we_i = 1'b0; mem_op_i = 3'b010;
    mem_addr_i = 32'h4000; reg_we_i = 1'b1; reg_waddr_i = 5'd9; dbus_gnt_i = 1'b1;
    #4;
    chk("lw4000 req", {31'd0, dbus_req_o}, 32'd1);
    @(posedge clk_i); #1;
    dbus_gnt_i = 1'b0;
    #3;
    chk("lw4000 resp stall", {31'd0, stall_o}, 32'd1);
    rst_i = 1'b0; valid_i = 1'b0;
    #1;
    chk("midrst stall", {31'd0, stall_o}, 32'd0);
    chk("midrst we", {31'd0, reg_we_o}, 32'd0);
    chk("midrst wdata", reg_wdata_o, 32'd0);
    chk("midrst req", {31'd0, dbus_req_o}, 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b1; dbus_rvalid_i = 1'b1; dbus_rdata_i = 32'hCAFE_F00D;
    #4;
    chk("late rvalid we", {31'd0, reg_we_o}, 32'd0);
    chk("late rvalid stall", {31'd0, stall_o}, 32'd0);
    chk("late rvalid req", {31'd0, dbus_req_o}, 32'd0);
    @(posedge clk_i); #1;
    dbus_rvalid_i = 1'b0;
    valid_i = 1'b1; mem_re_i = 1'b0; reg_wdata_i = 32'h0BAD_0001;
    #4;
    chk("post rst alu we", {31'd0, reg_we_o}, 32'd1);
    chk("post rst alu wdata", reg_wdata_o, 32'h0BAD_0001);
    chk("post rst stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk_i); #1;

    // Random accesses against the reference model.
    for (int k = 0; k < 60; k++) begin
      logic        ld;
      logic [2:0]  op;
      logic [31:0] addr, wd, rd;
      int          g, r, ops_ld[5], ops_st[3];
      logic        we;
      ops_ld = '{0, 1, 2, 4, 5};
      ops_st = '{0, 1, 2};
      ld   = 1'($urandom_range(0, 1));
      op   = ld ? 3'(ops_ld[$urandom_range(0, 4)]) : 3'(ops_st[$urandom_range(0, 2)]);
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      wd   = $urandom;
      rd   = $urandom;
      g    = $urandom_range(0, 3);
      r    = $urandom_range(1, 3);
      we   = 1'($urandom_range(0, 1));
      do_access("rnd", ld, op, addr, wd, rd, g, r, we, 5'($urandom),
                m_mis(op, addr), m_be(ld, op, addr), m_wdata(op, wd),
                m_load(op, addr, rd), m_mis(op, addr) ? 0 : (ld ? g + r : g));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
